// File: rtl/wallclock_pkg.sv
// Shared definitions for the wallclock display path: active-low segment
// patterns, digit count and the scan-slot state encoding.
package wallclock_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low 7-bit patterns {G,F,E,D,C,B,A}; DP is added by the scan driver.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } scan_state_e;

  function automatic scan_state_e next_slot(input scan_state_e s);
    return scan_state_e'(2'(s + 2'd1));
  endfunction

  // Anode enable for one used digit position, active-low; upper anodes stay off.
  function automatic logic [7:0] anode_mask(input scan_state_e s);
    return ~(8'h01 << s);
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9 show a dash.
module bcd_to_seg
  import wallclock_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/ss_scan_driver.sv
// Time-multiplexed HH:MM scan driver for an 8-digit common-anode display with
// PWM dimming and per-frame digit latching. Optional macro: LEADING_ZERO_BLANK_EN.
module ss_scan_driver
  import wallclock_pkg::*;
#(
  parameter int SCAN_BITS = 17,
  parameter int PWM_BITS  = 8
) (
  input  logic                CLK100MHZ,
  input  logic                RESET_N,
  input  logic [3:0]          BCD3,
  input  logic [3:0]          BCD2,
  input  logic [3:0]          BCD1,
  input  logic [3:0]          BCD0,
  input  logic [PWM_BITS-1:0] PWM_IN,
  output logic [7:0]          SegmentDrivers,
  output logic [7:0]          SevenSegment
);

  scan_state_e                      state_q;
  logic [SCAN_BITS-1:0]             cnt_q;
  logic [NUM_DIGITS-1:0][3:0]       digits_q;
  logic                             first_q;
  logic [7:0]                       an_q;
  logic [7:0]                       seg_q;

  logic                             cnt_wrap;
  logic                             load_frame;
  logic [NUM_DIGITS-1:0][3:0]       frame_digits;
  logic [3:0]                       active_bcd;
  logic [6:0]                       active_seg7;
  logic                             pwm_on;
  logic                             blank;
  logic                             dp_n;
  logic [7:0]                       an_d;
  logic [7:0]                       seg_d;

  assign cnt_wrap   = &cnt_q;
  assign load_frame = first_q || (cnt_wrap && (state_q == SLOT3));

  // On the first cycle after reset the new frame is shown straight from the
  // inputs so the display never flashes the cleared latch contents.
  assign frame_digits = first_q ? {BCD3, BCD2, BCD1, BCD0} : digits_q;
  assign active_bcd   = frame_digits[state_q];

  bcd_to_seg u_bcd_to_seg (
    .bcd_i (active_bcd),
    .seg_o (active_seg7)
  );

  assign pwm_on = (cnt_q[PWM_BITS-1:0] < PWM_IN);
  assign dp_n   = (state_q != SLOT2);

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = (state_q == SLOT3) && (frame_digits[3] == 4'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d  = 8'hFF;
    seg_d = {dp_n, active_seg7};
    if (blank) begin
      seg_d = {1'b1, SEG_BLANK};
    end else if (pwm_on) begin
      an_d = anode_mask(state_q);
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!RESET_N) begin
      state_q  <= SLOT0;
      cnt_q    <= '0;
      digits_q <= '0;
      first_q  <= 1'b1;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      cnt_q   <= cnt_q + SCAN_BITS'(1);
      first_q <= 1'b0;
      if (cnt_wrap) begin
        state_q <= next_slot(state_q);
      end
      if (load_frame) begin
        digits_q <= {BCD3, BCD2, BCD1, BCD0};
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign SegmentDrivers = an_q;
  assign SevenSegment   = seg_q;

endmodule

// File: tb/tb_ss_scan_driver.sv
// Directed bench for ss_scan_driver (SCAN_BITS=10, PWM_BITS=8); honours LEADING_ZERO_BLANK_EN.
module tb_ss_scan_driver;

  localparam int SB = 10;
  localparam int PB = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] bcd3, bcd2, bcd1, bcd0;
  logic [7:0] pwm;
  logic [7:0] an;
  logic [7:0] seg;

  int tests;
  int fails;
  int cyc;

  ss_scan_driver #(.SCAN_BITS(SB), .PWM_BITS(PB)) dut (
    .CLK100MHZ      (clk),
    .RESET_N        (rst_n),
    .BCD3           (bcd3),
    .BCD2           (bcd2),
    .BCD1           (bcd1),
    .BCD0           (bcd0),
    .PWM_IN         (pwm),
    .SegmentDrivers (an),
    .SevenSegment   (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] b3, b2, b1, b0;
    logic [7:0] pwm;
    int         n;
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [7:0] dec(input logic [3:0] b);
    case (b)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Hold reset for three edges with the given inputs, then release; cyc=0 is the
  // first sample after the first edge with reset high.
  task automatic do_reset(input logic [3:0] a3, a2, a1, a0, input logic [7:0] p);
    rst_n = 1'b0;
    bcd3 = a3; bcd2 = a2; bcd1 = a1; bcd0 = a0; pwm = p;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_an", an, 8'hFF);
      chk("reset_seg", seg, 8'hFF);
    end
    rst_n = 1'b1;
    cyc = -1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bcd3 = 0; bcd2 = 0; bcd1 = 0; bcd0 = 0; pwm = 0;

    vecs[0]  = '{4'd1, 4'd2, 4'd3, 4'd4, 8'd255, 0,         8'hFE, 8'h99};
    vecs[1]  = '{4'd1, 4'd2, 4'd3, 4'd4, 8'd255, 255,       8'hFF, 8'h99};
    vecs[2]  = '{4'd1, 4'd2, 4'd3, 4'd4, 8'd255, 1029,      8'hFD, 8'hB0};
    vecs[3]  = '{4'd1, 4'd2, 4'd3, 4'd4, 8'd255, 2148,      8'hFB, 8'h24};
    vecs[4]  = '{4'd1, 4'd2, 4'd3, 4'd4, 8'd255, 3326,      8'hF7, 8'hF9};
    vecs[5]  = '{4'd1, 4'd2, 4'd3, 4'd4, 8'd255, 4096,      8'hFE, 8'h99};
    vecs[6]  = '{4'd1, 4'd2, 4'd3, 4'd4, 8'd0,   10,        8'hFF, 8'h99};
    vecs[7]  = '{4'd1, 4'd2, 4'd3, 4'd4, 8'd128, 127,       8'hFE, 8'h99};
    vecs[8]  = '{4'd1, 4'd2, 4'd3, 4'd4, 8'd128, 128,       8'hFF, 8'h99};
    vecs[9]  = '{4'd1, 4'd2, 4'hA, 4'd4, 8'd200, 1027,      8'hFD, 8'hBF};
    vecs[10] = '{4'd0, 4'd9, 4'd5, 4'd6, 8'd50,  2097,      8'hFB, 8'h10};
    vecs[11] = '{4'd0, 4'd9, 4'd5, 4'd6, 8'd50,  2098,      8'hFF, 8'h10};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[12] = '{4'd0, 4'd9, 4'd5, 4'd6, 8'd50,  3077,      8'hFF, 8'hFF};
`else
    vecs[12] = '{4'd0, 4'd9, 4'd5, 4'd6, 8'd50,  3077,      8'hF7, 8'hC0};
`endif
    vecs[13] = '{4'd8, 4'd8, 4'd8, 4'd7, 8'd1,   256,       8'hFE, 8'hF8};
    vecs[14] = '{4'hF, 4'd6, 4'd0, 4'd5, 8'd255, 1025,      8'hFD, 8'hC0};
    vecs[15] = '{4'hF, 4'd6, 4'd0, 4'd5, 8'd255, 3073,      8'hF7, 8'hBF};

    for (int i = 0; i < 16; i++) begin
      do_reset(vecs[i].b3, vecs[i].b2, vecs[i].b1, vecs[i].b0, vecs[i].pwm);
      run_to(vecs[i].n);
      chk($sformatf("vec%0d_an", i), an, vecs[i].exp_an);
      chk($sformatf("vec%0d_seg", i), seg, vecs[i].exp_seg);
    end

    // Full frame at PWM 255 against a small reference model.
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 8'd255);
    for (int n = 0; n < 4096; n++) begin
      int          slot;
      logic [3:0]  d;
      logic [7:0]  e_seg;
      logic [7:0]  e_an;
      run_to(n);
      slot  = (n / 1024) % 4;
      d     = (slot == 0) ? 4'd4 : (slot == 1) ? 4'd3 : (slot == 2) ? 4'd2 : 4'd1;
      e_seg = dec(d) & ((slot == 2) ? 8'h7F : 8'hFF);
      e_an  = ((n % 256) < 255) ? ~(8'h01 << slot) : 8'hFF;
      chk($sformatf("frame_an_n%0d", n), an, e_an);
      chk($sformatf("frame_seg_n%0d", n), seg, e_seg);
    end

    // PWM 128 duty over one 256-cycle window, then PWM 0 for a full frame.
    begin
      int lows;
      do_reset(4'd1, 4'd2, 4'd3, 4'd4, 8'd128);
      lows = 0;
      for (int n = 1024; n < 1280; n++) begin
        run_to(n);
        if (an == 8'hFD) lows++;
      end
      chk("pwm128_low_count", 8'(lows), 8'd128);
      pwm  = 8'd0;
      lows = 0;
      for (int n = 1280; n < 1280 + 4096; n++) begin
        run_to(n);
        if (an != 8'hFF) lows++;
      end
      chk("pwm0_frame_low_count", 8'(lows), 8'd0);
    end

    // Mid-frame digit change is held off until the next frame boundary.
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 8'd255);
    run_to(1536);
    bcd0 = 4'd7;
    run_to(1600);
    chk("midchg_slot1_seg", seg, 8'hB0);
    run_to(4095);
    chk("midchg_slot3_seg", seg, 8'hF9);
    run_to(4096);
    chk("midchg_next_an", an, 8'hFE);
    chk("midchg_next_seg", seg, 8'hF8);
    run_to(4096 + 700);
    chk("midchg_next_mid_seg", seg, 8'hF8);

    // Reset pulse during SLOT2 restarts the scan and reloads the digits.
    do_reset(4'd1, 4'd2, 4'hA, 4'd4, 8'd255);
    run_to(1030);
    chk("dash_slot1_seg", seg, 8'hBF);
    run_to(2058);
    chk("pre_reset_slot2_seg", seg, 8'h24);
    rst_n = 1'b0;
    bcd0  = 4'd5;
    tick();
    chk("midreset_an", an, 8'hFF);
    chk("midreset_seg", seg, 8'hFF);
    rst_n = 1'b1;
    cyc   = -1;
    tick();
    chk("restart_an", an, 8'hFE);
    chk("restart_seg", seg, 8'h92);
    run_to(1024);
    chk("restart_slot1_an", an, 8'hFD);
    chk("restart_slot1_seg", seg, 8'hBF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
